// File: rtl/draw_scheduler.sv
// Frame-paced round-robin scheduler that hands a shared VGA write port to three
// drawing clients (pacman, ghost0, ghost1) once per frame, with a per-client watchdog.
module draw_scheduler #(
  parameter int unsigned FRAME_TICKS = 833334,
  parameter int unsigned TIMEOUT     = 1023
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  output logic [2:0] go,
  input  logic [2:0] done,
  input  logic [7:0] cx0,
  input  logic [7:0] cx1,
  input  logic [7:0] cx2,
  input  logic [6:0] cy0,
  input  logic [6:0] cy1,
  input  logic [6:0] cy2,
  input  logic [2:0] ccol0,
  input  logic [2:0] ccol1,
  input  logic [2:0] ccol2,
  input  logic [2:0] cplot,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       frame_start,
  output logic       busy,
  output logic [1:0] active,
  output logic       timeout_err,
  output logic       overrun
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    NEXT  = 2'd3
  } state_t;

  localparam logic [19:0] LAST_TICK = 20'(FRAME_TICKS - 1);
  // The watchdog counts WAIT cycles; it reaches TIMEOUT on the last permitted one.
  localparam logic [9:0]  WD_LAST   = 10'(TIMEOUT - 1);

  state_t      state_r;
  state_t      state_nxt_s;
  logic [1:0]  idx_r;
  logic [1:0]  idx_nxt_s;
  logic [9:0]  wd_r;
  logic [9:0]  wd_nxt_s;
  logic [19:0] frame_cnt_r;
  logic        tick_s;
  logic        done_sel_s;
  logic        plot_sel_s;
  logic        timeout_set_s;
  logic [2:0]  go_r;
  logic        frame_start_r;
  logic        busy_r;
  logic        plot_en_r;
  logic        timeout_err_r;
  logic        overrun_r;
  logic [7:0]  vga_x_s;
  logic [6:0]  vga_y_s;
  logic [2:0]  colour_s;

  function automatic logic [2:0] onehot3(input logic [1:0] i);
    case (i)
      2'd0:    return 3'b001;
      2'd1:    return 3'b010;
      2'd2:    return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  // Frame period counter; held at zero while disabled so re-enabling restarts a full period.
  always_ff @(posedge clock) begin
    if (reset) begin
      frame_cnt_r <= 20'd0;
    end else if (!enable) begin
      frame_cnt_r <= 20'd0;
    end else if (frame_cnt_r == LAST_TICK) begin
      frame_cnt_r <= 20'd0;
    end else begin
      frame_cnt_r <= frame_cnt_r + 20'd1;
    end
  end

  assign tick_s = enable && (frame_cnt_r == LAST_TICK);

  // Select the owning client's pixel, done and write-enable.
  always_comb begin
    vga_x_s    = 8'd0;
    vga_y_s    = 7'd0;
    colour_s   = 3'd0;
    done_sel_s = 1'b0;
    plot_sel_s = 1'b0;
    case (idx_r)
      2'd0: begin
        vga_x_s = cx0; vga_y_s = cy0; colour_s = ccol0;
        done_sel_s = done[0]; plot_sel_s = cplot[0];
      end
      2'd1: begin
        vga_x_s = cx1; vga_y_s = cy1; colour_s = ccol1;
        done_sel_s = done[1]; plot_sel_s = cplot[1];
      end
      2'd2: begin
        vga_x_s = cx2; vga_y_s = cy2; colour_s = ccol2;
        done_sel_s = done[2]; plot_sel_s = cplot[2];
      end
      default: begin
        vga_x_s = 8'd0; vga_y_s = 7'd0; colour_s = 3'd0;
        done_sel_s = 1'b0; plot_sel_s = 1'b0;
      end
    endcase
  end

  // Next-state logic; a done on the final watchdog cycle takes priority over the timeout.
  always_comb begin
    state_nxt_s   = state_r;
    idx_nxt_s     = idx_r;
    wd_nxt_s      = wd_r;
    timeout_set_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (tick_s) begin
          state_nxt_s = ISSUE;
          idx_nxt_s   = 2'd0;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ISSUE: begin
        state_nxt_s = WAIT;
        wd_nxt_s    = 10'd0;
      end
      WAIT: begin
        wd_nxt_s = wd_r + 10'd1;
        if (done_sel_s) begin
          state_nxt_s = NEXT;
        end else if (wd_r == WD_LAST) begin
          state_nxt_s   = NEXT;
          timeout_set_s = 1'b1;
        end else begin
          state_nxt_s = WAIT;
        end
      end
      NEXT: begin
        if (idx_r == 2'd2) begin
          state_nxt_s = IDLE;
          idx_nxt_s   = 2'd0;
        end else begin
          state_nxt_s = ISSUE;
          idx_nxt_s   = idx_r + 2'd1;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        idx_nxt_s   = 2'd0;
      end
    endcase
  end

  // State, sticky flags and Moore outputs registered from the next state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r       <= IDLE;
      idx_r         <= 2'd0;
      wd_r          <= 10'd0;
      go_r          <= 3'b000;
      frame_start_r <= 1'b0;
      busy_r        <= 1'b0;
      plot_en_r     <= 1'b0;
      timeout_err_r <= 1'b0;
      overrun_r     <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      idx_r         <= idx_nxt_s;
      wd_r          <= wd_nxt_s;
      go_r          <= (state_nxt_s == ISSUE) ? onehot3(idx_nxt_s) : 3'b000;
      frame_start_r <= (state_nxt_s == ISSUE) && (idx_nxt_s == 2'd0);
      busy_r        <= (state_nxt_s != IDLE);
      plot_en_r     <= (state_nxt_s == WAIT);
      timeout_err_r <= timeout_err_r | timeout_set_s;
      overrun_r     <= overrun_r | (tick_s && (state_r != IDLE));
    end
  end

  assign go          = go_r;
  assign frame_start = frame_start_r;
  assign busy        = busy_r;
  assign active      = idx_r;
  assign timeout_err = timeout_err_r;
  assign overrun     = overrun_r;
  assign vga_x       = vga_x_s;
  assign vga_y       = vga_y_s;
  assign colour      = colour_s;
  assign plot        = plot_en_r & plot_sel_s;

endmodule

// File: tb/tb_draw_scheduler.sv
// Directed bench for draw_scheduler: client responders with programmable latency,
// per-cycle logging on the falling edge, and hand-computed cycle expectations.
module tb_draw_scheduler;

  // A minimum frame is 9 cycles, so a 16-cycle period lets frames repeat without overrun.
  localparam int FT = 16;
  localparam int TO = 16;

  logic       clock;
  logic       reset;
  logic       enable;
  logic [2:0] go;
  logic [2:0] done;
  logic [7:0] cx0, cx1, cx2;
  logic [6:0] cy0, cy1, cy2;
  logic [2:0] ccol0, ccol1, ccol2;
  logic [2:0] cplot;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] colour;
  logic       plot;
  logic       frame_start;
  logic       busy;
  logic [1:0] active;
  logic       timeout_err;
  logic       overrun;

  int n_tests = 0;
  int n_fail  = 0;

  int dly  [3];
  int hold [3];
  int wcnt [3];
  int hcnt [3];

  int cyc;
  int fs_cnt;
  int last_fs;
  int go_n;
  int busy_cnt;
  int plot_cnt [4];
  logic [2:0] go_log [8];

  draw_scheduler #(.FRAME_TICKS(FT), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset), .enable(enable), .go(go), .done(done),
    .cx0(cx0), .cx1(cx1), .cx2(cx2), .cy0(cy0), .cy1(cy1), .cy2(cy2),
    .ccol0(ccol0), .ccol1(ccol1), .ccol2(ccol2), .cplot(cplot),
    .vga_x(vga_x), .vga_y(vga_y), .colour(colour), .plot(plot),
    .frame_start(frame_start), .busy(busy), .active(active),
    .timeout_err(timeout_err), .overrun(overrun)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  // Client model: pulse done[i] dly[i] cycles after seeing go[i] (dly 0 = never).
  initial begin
    done = 3'b000;
    for (int i = 0; i < 3; i++) begin
      wcnt[i] = 0;
      hcnt[i] = 0;
    end
    forever begin
      @(negedge clock);
      for (int i = 0; i < 3; i++) begin
        if (reset) begin
          wcnt[i] = 0;
          hcnt[i] = 0;
          done[i] = 1'b0;
        end else begin
          if (hcnt[i] > 0) begin
            hcnt[i]--;
            if (hcnt[i] == 0) done[i] = 1'b0;
          end
          if (wcnt[i] > 0) begin
            wcnt[i]--;
            if (wcnt[i] == 0) begin
              done[i] = 1'b1;
              hcnt[i] = hold[i];
            end
          end
          if (go[i] && dly[i] > 0) wcnt[i] = dly[i];
        end
      end
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    cyc = 0; fs_cnt = 0; last_fs = 0; go_n = 0; busy_cnt = 0;
    for (int i = 0; i < 4; i++) plot_cnt[i] = 0;
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(negedge clock);
      cyc++;
      if (frame_start) begin
        fs_cnt++;
        last_fs = cyc;
      end
      if (go != 3'b000 && go_n < 8) begin
        go_log[go_n] = go;
        go_n++;
      end
      if (plot) plot_cnt[active]++;
      if (busy) busy_cnt++;
    end
  endtask

  task automatic start(input logic en);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    enable = en;
    reset  = 1'b0;
    clear_log();
  endtask

  task automatic set_dly(input int d0, input int d1, input int d2);
    dly[0] = d0; dly[1] = d1; dly[2] = d2;
  endtask

  function automatic logic [8:0] go_seq();
    return {go_log[0], go_log[1], go_log[2]};
  endfunction

  initial begin
    reset = 1'b1; enable = 1'b1; cplot = 3'b111;
    cx0 = 8'd11;  cy0 = 7'd21; ccol0 = 3'd1;
    cx1 = 8'd100; cy1 = 7'd50; ccol1 = 3'b110;
    cx2 = 8'd200; cy2 = 7'd99; ccol2 = 3'd3;
    set_dly(0, 0, 0);
    for (int i = 0; i < 3; i++) hold[i] = 1;
    clear_log();

    // Reset state
    repeat (3) @(negedge clock);
    check_val("rst_go", go, 0);
    check_val("rst_plot", plot, 0);
    check_val("rst_fs", frame_start, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_active", active, 0);
    check_val("rst_terr", timeout_err, 0);
    check_val("rst_ovr", overrun, 0);
    check_val("rst_vga_x", vga_x, 11);

    // Normal frames, each client done 3 cycles after its go
    set_dly(3, 3, 3);
    start(1'b1);
    run(FT - 1);
    check_val("t1_no_early_fs", fs_cnt, 0);
    run(1);
    check_val("t1_fs", frame_start, 1);
    check_val("t1_fs_cycle", last_fs, FT);
    check_val("t1_go0", go, 3'b001);
    run(15);
    check_val("t1_idle", busy, 0);
    check_val("t1_len", busy_cnt, 15);
    check_val("t1_go_n", go_n, 3);
    check_val("t1_go_seq", go_seq(), 9'b001_010_100);
    run(1);
    check_val("t1_fs2", frame_start, 1);
    run(31);
    check_val("t1_fs_cnt", fs_cnt, 3);
    check_val("t1_ovr", overrun, 0);
    check_val("t1_terr", timeout_err, 0);

    // Minimum frame: done on the first WAIT cycle
    set_dly(1, 1, 1);
    start(1'b1);
    run(FT + 9);
    check_val("min_idle", busy, 0);
    check_val("min_len", busy_cnt, 9);
    check_val("min_go_seq", go_seq(), 9'b001_010_100);

    // Client1 never signals done
    set_dly(1, 0, 1);
    start(1'b1);
    run(35);
    check_val("t2_no_early_to", timeout_err, 0);
    check_val("t2_wait1_16", plot_cnt[1], 16);
    run(1);
    check_val("t2_to_set", timeout_err, 1);
    check_val("t2_plot_next", plot, 0);
    run(4);
    check_val("t2_idle", busy, 0);
    check_val("t2_go_seq", go_seq(), 9'b001_010_100);
    check_val("t2_plot0", plot_cnt[0], 1);
    check_val("t2_plot2", plot_cnt[2], 1);
    check_val("t2_ovr", overrun, 1);
    run(20);
    check_val("t2_to_sticky", timeout_err, 1);
    check_val("t2_fs_cnt", fs_cnt, 2);

    // Slow client0 spans the next tick
    set_dly(14, 1, 1);
    start(1'b1);
    run(31);
    check_val("t3_ovr_before", overrun, 0);
    run(1);
    check_val("t3_ovr_set", overrun, 1);
    check_val("t3_tick_dropped", frame_start, 0);
    check_val("t3_go1", go, 3'b010);
    run(15);
    check_val("t3_idle", busy, 0);
    check_val("t3_fs_cnt", fs_cnt, 1);
    check_val("t3_go_seq", go_seq(), 9'b001_010_100);
    run(1);
    check_val("t3_fs_later", frame_start, 1);

    // Port mux while client1 owns the port, then reset in client2 WAIT
    set_dly(1, 0, 0);
    cplot = 3'b010;
    start(1'b1);
    run(25);
    check_val("t4_active", active, 1);
    check_val("t4_vga_x", vga_x, 100);
    check_val("t4_vga_y", vga_y, 50);
    check_val("t4_colour", colour, 3'b110);
    check_val("t4_plot", plot, 1);
    cplot = 3'b001;
    #1;
    check_val("t4_cplot0_blocked", plot, 0);
    cplot = 3'b111;
    run(15);
    check_val("t4_active2", active, 2);
    check_val("t4_plot2", plot, 1);
    check_val("t4_terr", timeout_err, 1);
    check_val("t4_ovr", overrun, 1);
    reset = 1'b1;
    @(negedge clock);
    check_val("t4_rst_go", go, 0);
    check_val("t4_rst_plot", plot, 0);
    check_val("t4_rst_busy", busy, 0);
    check_val("t4_rst_active", active, 0);
    check_val("t4_rst_terr", timeout_err, 0);
    check_val("t4_rst_ovr", overrun, 0);
    set_dly(1, 1, 1);
    reset = 1'b0;
    clear_log();
    run(FT);
    check_val("t4_restart_fs", frame_start, 1);
    check_val("t4_restart_go", go, 3'b001);
    check_val("t4_restart_x", vga_x, 11);

    // Disabled from reset, then enable dropped during client1
    start(1'b0);
    run(100);
    check_val("t5_no_fs", fs_cnt, 0);
    check_val("t5_no_go", go_n, 0);
    check_val("t5_no_plot", plot_cnt[0] + plot_cnt[1] + plot_cnt[2], 0);
    check_val("t5_no_busy", busy_cnt, 0);
    enable = 1'b1;
    run(FT);
    check_val("t5_fs", frame_start, 1);
    run(4);
    check_val("t5_active1", active, 1);
    enable = 1'b0;
    run(30);
    check_val("t5_fs_cnt", fs_cnt, 1);
    check_val("t5_go_n", go_n, 3);
    check_val("t5_go_seq", go_seq(), 9'b001_010_100);
    check_val("t5_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
